// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Bundles every handshake and bus signal of the load/store unit into one
//   interface.
//   slave  : the view used by mem_access_unit.
//   master : the view used by whatever drives requests and provides memory.
//
//   Pipeline request : req_valid, req_ready, req_write, req_func3[2:0],
//                      req_addr[31:0], req_wdata[31:0]
//   Pipeline response: resp_valid, resp_rdata[31:0], misalign_err
//   Memory side      : mem_read, mem_write, mem_func3[2:0], mem_addr[31:0],
//                      mem_wdata[31:0], mem_rdata[31:0] (combinational read data)
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;

  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, misalign_err,
           mem_read, mem_write, mem_func3, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, misalign_err,
           mem_read, mem_write, mem_func3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   RV32I load/store unit sitting between the pipeline and a single-cycle
//   memory. It accepts one request at a time, checks the width code and the
//   alignment, performs the memory access and returns a one-cycle response.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - mem_access_unit_if.slave (request, response and memory signals)
//
//   Build option:
//     MISALIGNED_SPLIT_EN - when defined, misaligned halfword/word accesses are
//     broken into consecutive byte accesses. When undefined, a misaligned
//     access completes immediately with misalign_err set and no memory strobe.
module mem_access_unit (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, DONE} state_t;

  state_t      state;

  // Request captured at accept; drives the memory port while busy.
  logic        lat_write;
  logic [2:0]  lat_func3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        rd_q;
  logic        wr_q;
  logic        resp_valid_q;
  logic        misalign_q;
  logic [31:0] rdata_q;

  logic        req_legal;
  logic        req_misaligned;

`ifdef MISALIGNED_SPLIT_EN
  logic [1:0]  byte_cnt;
  logic [31:0] split_buf;
  logic [31:0] split_full;
  logic        split_last;

  // Split loads rebuild the value byte by byte, so the extension the memory
  // normally applies has to be done here instead.
  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [31:0] v);
    case (f3)
      3'd1:    extend_load = {{16{v[15]}}, v[15:0]};
      3'd5:    extend_load = {16'd0, v[15:0]};
      default: extend_load = v;
    endcase
  endfunction
`endif

  // Decode the incoming width code: legality depends on direction (stores
  // have no unsigned variants), alignment on the access size.
  always_comb begin
    req_legal = 1'b0;
    case (bus.req_func3)
      3'd0, 3'd1, 3'd2: req_legal = 1'b1;
      3'd4, 3'd5:       req_legal = ~bus.req_write;
      default:          req_legal = 1'b0;
    endcase

    req_misaligned = 1'b0;
    case (bus.req_func3)
      3'd1, 3'd5: req_misaligned = bus.req_addr[0];
      3'd2:       req_misaligned = |bus.req_addr[1:0];
      default:    req_misaligned = 1'b0;
    endcase
  end

`ifdef MISALIGNED_SPLIT_EN
  // Merge the byte arriving this cycle into the partially built result and
  // flag the final byte (2 for halfwords, 4 for words).
  always_comb begin
    split_full = split_buf;
    split_full[{byte_cnt, 3'b000} +: 8] = bus.mem_rdata[7:0];
    split_last = (lat_func3[1:0] == 2'b01) ? (byte_cnt == 2'd1)
                                           : (byte_cnt == 2'd3);
  end
`endif

  // Memory port: strobes are forced low while rst is high so an aborted
  // access never reaches memory, even in the reset cycle itself.
  always_comb begin
    bus.mem_read  = rd_q & ~rst;
    bus.mem_write = wr_q & ~rst;
    bus.mem_func3 = lat_func3;
    bus.mem_addr  = lat_addr;
    bus.mem_wdata = lat_wdata;
`ifdef MISALIGNED_SPLIT_EN
    if (state == SPLIT) begin
      bus.mem_func3 = 3'd0;
      bus.mem_addr  = lat_addr + {30'd0, byte_cnt};
      bus.mem_wdata = {24'd0, lat_wdata[{byte_cnt, 3'b000} +: 8]};
    end
`endif
  end

  assign bus.req_ready    = (state == IDLE) & ~rst;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.misalign_err = misalign_q;

  // Control FSM. Every response and strobe is registered here; DONE is the
  // single cycle in which resp_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_write    <= 1'b0;
      lat_func3    <= 3'd0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      rdata_q      <= 32'd0;
`ifdef MISALIGNED_SPLIT_EN
      byte_cnt     <= 2'd0;
      split_buf    <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          if (bus.req_valid) begin
            lat_write <= bus.req_write;
            lat_func3 <= bus.req_func3;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            if (!req_legal) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              rdata_q      <= 32'd0;
            end else if (req_misaligned) begin
`ifdef MISALIGNED_SPLIT_EN
              state     <= SPLIT;
              byte_cnt  <= 2'd0;
              split_buf <= 32'd0;
              rd_q      <= ~bus.req_write;
              wr_q      <= bus.req_write;
`else
              state        <= DONE;
              resp_valid_q <= 1'b1;
              misalign_q   <= 1'b1;
`endif
            end else begin
              state <= ACCESS;
              rd_q  <= ~bus.req_write;
              wr_q  <= bus.req_write;
            end
          end
        end

        ACCESS: begin
          rd_q         <= 1'b0;
          wr_q         <= 1'b0;
          rdata_q      <= lat_write ? 32'd0 : bus.mem_rdata;
          resp_valid_q <= 1'b1;
          state        <= DONE;
        end

        SPLIT: begin
`ifdef MISALIGNED_SPLIT_EN
          split_buf <= split_full;
          if (split_last) begin
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            rdata_q      <= lat_write ? 32'd0 : extend_load(lat_func3, split_full);
            resp_valid_q <= 1'b1;
            state        <= DONE;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
`else
          state <= IDLE;
`endif
        end

        DONE: begin
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Randomised scoreboard bench for mem_access_unit. A byte-array memory
//   answers the DUT's memory port; a reference model works on a second copy
//   of memory in whole-transaction terms (bytes in, little-endian value out)
//   and queues the expected response and memory strobes for a monitor.
//   Works with or without MISALIGNED_SPLIT_EN defined.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accept_edge;
    int          latency;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  func3;
    logic        write;
  } strobe_t;

  logic [7:0]  mem     [0:255];
  logic [7:0]  ref_mem [0:255];
  resp_t       resp_q[$];
  strobe_t     strobe_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle_cnt = 0;
  logic [31:0] cur_rdata = 32'd0;
  logic        ready_due = 1'b0;

  logic [7:0]  rd_base;
  logic [31:0] rd_word;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Memory read side: combinational, extended according to mem_func3.
  assign rd_base = bus.mem_addr[7:0];
  always_comb begin
    rd_word = {mem[8'(rd_base + 8'd3)], mem[8'(rd_base + 8'd2)],
               mem[8'(rd_base + 8'd1)], mem[rd_base]};
    case (bus.mem_func3)
      3'd0:    bus.mem_rdata = {{24{rd_word[7]}}, rd_word[7:0]};
      3'd4:    bus.mem_rdata = {24'd0, rd_word[7:0]};
      3'd1:    bus.mem_rdata = {{16{rd_word[15]}}, rd_word[15:0]};
      3'd5:    bus.mem_rdata = {16'd0, rd_word[15:0]};
      default: bus.mem_rdata = rd_word;
    endcase
  end

  // Memory write side: commits the strobed bytes at the clock edge.
  always @(posedge clk) begin : mem_wr
    int nb;
    if (bus.mem_write) begin
      nb = (bus.mem_func3[1:0] == 2'd0) ? 1 : (bus.mem_func3[1:0] == 2'd1) ? 2 : 4;
      for (int i = 0; i < 4; i++)
        if (i < nb) mem[8'(bus.mem_addr[7:0] + 8'(i))] <= bus.mem_wdata[8*i +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: whole-transaction behaviour in terms of bytes.
  function automatic void model_issue(input logic write, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input int accept_edge);
    int          n;
    logic        legal;
    logic        mis;
    logic [31:0] val;
    resp_t       r;
    strobe_t     s;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = write ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = legal && ((addr % 32'(n)) != 32'd0);
    r.accept_edge = accept_edge;
    r.err   = 1'b0;
    r.rdata = 32'd0;
    if (!legal) begin
      r.latency = 1;
      cur_rdata = 32'd0;
    end else if (mis && !SplitEn) begin
      r.latency = 1;
      r.err     = 1'b1;
      r.rdata   = cur_rdata;
    end else begin
      r.latency = mis ? n + 1 : 2;
      if (mis) begin
        for (int i = 0; i < n; i++) begin
          s.addr = 32'(addr + 32'(i)); s.func3 = 3'd0; s.write = write;
          strobe_q.push_back(s);
        end
      end else begin
        s.addr = addr; s.func3 = f3; s.write = write;
        strobe_q.push_back(s);
      end
      if (write) begin
        for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
        cur_rdata = 32'd0;
      end else begin
        val = 32'd0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[8'(addr + 32'(i))];
        if (f3 == 3'd0) val = {{24{val[7]}}, val[7:0]};
        if (f3 == 3'd1) val = {{16{val[15]}}, val[15:0]};
        r.rdata   = val;
        cur_rdata = val;
      end
    end
    resp_q.push_back(r);
  endfunction

  task automatic waitReady(output bit ok);
    int guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = bus.req_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: req_ready=%0b required=1", bus.req_ready);
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    waitReady(ok);
    if (!ok) return;
    model_issue(write, f3, addr, wdata, cycle_cnt + 1);
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Issue a word store and hit reset after `bytes_done` memory cycles; only
  // the bytes already written may have reached memory, and no response follows.
  task automatic abortStore(input logic [31:0] addr, input logic [31:0] wdata,
                            input int bytes_done);
    bit      ok;
    strobe_t s;
    waitReady(ok);
    if (!ok) return;
    for (int i = 0; i < bytes_done; i++) begin
      s.addr = 32'(addr + 32'(i)); s.func3 = 3'd0; s.write = 1'b1;
      strobe_q.push_back(s);
      ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_func3 = 3'd2;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    repeat (bytes_done) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cur_rdata = 32'd0;
    @(negedge clk);
    checkOutput("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("abort_rdata", bus.resp_rdata, 32'd0);
    checkOutput("abort_err", {31'd0, bus.misalign_err}, 32'd0);
  endtask

  // Monitor: matches strobes and responses against the queued expectations.
  always @(negedge clk) begin : monitor
    strobe_t s;
    resp_t   r;
    if (rst) begin
      checkOutput("strobe_in_reset", {31'd0, bus.mem_read | bus.mem_write}, 32'd0);
      ready_due = 1'b0;
    end else begin
      if (ready_due) checkOutput("ready_after_resp", {31'd0, bus.req_ready}, 32'd1);
      ready_due = 1'b0;
      if (bus.mem_read | bus.mem_write) begin
        if (strobe_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_strobe: addr=0x%08h rd=%0b wr=%0b required none",
                   bus.mem_addr, bus.mem_read, bus.mem_write);
        end else begin
          s = strobe_q.pop_front();
          checkOutput("strobe_addr", bus.mem_addr, s.addr);
          checkOutput("strobe_func3", {29'd0, bus.mem_func3}, {29'd0, s.func3});
          checkOutput("strobe_kind", {30'd0, bus.mem_write, bus.mem_read},
                      {30'd0, s.write, ~s.write});
        end
      end
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: rdata=0x%08h err=%0b required no response",
                   bus.resp_rdata, bus.misalign_err);
        end else begin
          r = resp_q.pop_front();
          checkOutput("resp_rdata", bus.resp_rdata, r.rdata);
          checkOutput("resp_err", {31'd0, bus.misalign_err}, {31'd0, r.err});
          checkOutput("resp_latency", 32'(cycle_cnt - r.accept_edge + 1), 32'(r.latency));
        end
        ready_due = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [2:0]  f3;
    logic [31:0] addr;
    int          mem_bad;
    int          r;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_func3 = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    for (int i = 8'h10; i <= 8'h13; i++) ref_mem[i] = mem[i];

    $display("[TB] reset, split mode = %0b", SplitEn);
    repeat (3) @(negedge clk);
    checkOutput("ready_in_reset", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("reset_rdata", bus.resp_rdata, 32'd0);
    checkOutput("reset_err", {31'd0, bus.misalign_err}, 32'd0);

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 3'd2, 32'h10, 32'd0);
    applyStimulus(1'b1, 3'd1, 32'h20, 32'hAABBCCDD);
    applyStimulus(1'b0, 3'd5, 32'h20, 32'd0);
    applyStimulus(1'b0, 3'd1, 32'h20, 32'd0);
    applyStimulus(1'b1, 3'd2, 32'h31, 32'h01020304);
    applyStimulus(1'b0, 3'd2, 32'h31, 32'd0);
    applyStimulus(1'b0, 3'd1, 32'h41, 32'd0);
    applyStimulus(1'b0, 3'd3, 32'h08, 32'd0);
    applyStimulus(1'b1, 3'd4, 32'h08, 32'h12345678);
    applyStimulus(1'b1, 3'd6, 32'h0C, 32'h12345678);
    applyStimulus(1'b0, 3'd7, 32'h0C, 32'd0);
    applyStimulus(1'b1, 3'd2, 32'hFFFFFFFF, 32'hCAFEF00D);
    applyStimulus(1'b0, 3'd2, 32'hFFFFFFFF, 32'd0);
    applyStimulus(1'b0, 3'd5, 32'hFFFFFFFF, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'hFFFFFFFF, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'hFFFFFFFC, 32'd0);

    $display("[TB] reset abort");
    abortStore(32'h60, 32'h5A5A5A5A, 0);
`ifdef MISALIGNED_SPLIT_EN
    abortStore(32'h51, 32'hDEADBEEF, 1);
`endif
    applyStimulus(1'b0, 3'd2, 32'h60, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h50, 32'd0);

    $display("[TB] random accesses");
    for (int n = 0; n < 250; n++) begin
      r    = $urandom_range(0, 9);
      f3   = (r < 8) ? 3'(r) : ((r == 8) ? 3'd2 : 3'd1);
      addr = {(($urandom_range(0, 4) == 0) ? 24'hFFFFFF : 24'h000000), 8'($urandom)};
      applyStimulus(1'($urandom_range(0, 1)), f3, addr, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    for (int i = 0; i < 20 && resp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("leftover_resps", 32'(resp_q.size()), 32'd0);
    checkOutput("leftover_strobes", 32'(strobe_q.size()), 32'd0);
    mem_bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i] && mem_bad == 0)
        $display("[TB] first memory difference at 0x%02h: 0x%02h vs model 0x%02h",
                 i, mem[i], ref_mem[i]);
      if (mem[i] !== ref_mem[i]) mem_bad++;
    end
    checkOutput("memory_bytes_differing", 32'(mem_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The pipeline-side request port SHALL be: req_valid  input  1  request present; req_ready  output  1  unit can accept; req_write  input  1  1=store, 0=load; req_func3  input  3  RV32I width code (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU); req_addr  input  32  byte address; req_wdata  input  32  store data.
REQ-003 The pipeline-side response port SHALL be: resp_valid  output  1  one-cycle completion pulse; resp_rdata  output  32  extended load result; misalign_err  output  1  misaligned-access fault, valid with resp_valid.
REQ-004 The memory-side port SHALL be: mem_read  output  1  read strobe; mem_write  output  1  write strobe; mem_func3  output  3  access width code; mem_addr  output  32  byte address; mem_wdata  output  32  write data; mem_rdata  input  32  combinational read data, valid in the same cycle as mem_addr/mem_func3.

Function
REQ-005 FSM states SHALL be IDLE, ACCESS, SPLIT, DONE; req_ready = 1 only in IDLE with rst low.
REQ-006 Accept = req_valid & req_ready; on accept, write, func3, addr and wdata SHALL be latched and the unit SHALL leave IDLE.
REQ-007 Alignment: func3 0/4 always aligned; 1/5 misaligned if addr[0]=1; 2 misaligned if addr[1:0]!=0.
REQ-008 Legal codes: loads 0,1,2,4,5; stores 0,1,2; any other code SHALL go to DONE with no memory strobe, resp_rdata=0, misalign_err=0.
REQ-009 Aligned legal access: IDLE->ACCESS->DONE->IDLE; in ACCESS the unit SHALL drive exactly one strobe (mem_read or mem_write) with the latched func3/addr/wdata and SHALL capture mem_rdata for loads.
REQ-010 Latency: accept at edge T; memory strobe during cycle T..T+1; resp_valid high during the single cycle after edge T+1 (aligned); req_ready returns high the cycle after resp_valid.
REQ-011 resp_rdata SHALL hold the last captured load result until the next load completes; stores SHALL complete with resp_rdata=0.
REQ-012 Strobes SHALL be low in IDLE and DONE and whenever rst is high.
REQ-013 Load results via SPLIT SHALL be sign-extended for codes 0/1 and zero-extended for codes 4/5; the aligned path SHALL pass mem_rdata unchanged.
REQ-014 Address arithmetic for split bytes SHALL be 32-bit modulo 2^32 (0xFFFFFFFF+1 wraps to 0x00000000).

Reset
REQ-015 While rst is high at a rising edge: state->IDLE, byte counter->0, resp_valid->0, misalign_err->0, resp_rdata->0, latched request->0.
REQ-016 Reset asserted mid-ACCESS or mid-SPLIT SHALL abort the access; no strobe SHALL be driven in any cycle rst is high, and no response SHALL be issued for the aborted request.

Configuration
REQ-017 Macro MISALIGNED_SPLIT_EN SHALL select misaligned handling.
REQ-018 With MISALIGNED_SPLIT_EN defined: a misaligned legal access SHALL enter SPLIT, issue N byte accesses (N=2 halfword, 4 word) on consecutive cycles with mem_func3=0, mem_addr=addr+i, mem_wdata[7:0]=wdata byte i, capturing mem_rdata[7:0] into result byte i, i=0..N-1 ascending, then DONE with misalign_err=0.
REQ-019 Without MISALIGNED_SPLIT_EN: a misaligned access SHALL go IDLE->DONE with no strobe, resp_valid and misalign_err high together, resp_rdata unchanged.

Verification
REQ-020 Aligned LW addr 0x10, memory bytes 0x10..0x13 = 11 22 33 44 -> one mem_read cycle, resp_rdata=0x44332211, resp_valid 2 cycles after accept.
REQ-021 SH addr 0x20 wdata 0xAABBCCDD then LHU addr 0x20 -> resp_rdata=0x0000CCDD; LH same address -> 0xFFFFCCDD.
REQ-022 With MISALIGNED_SPLIT_EN: SW addr 0x31 wdata 0x01020304 -> 4 mem_write cycles to 0x31..0x34 with bytes 04,03,02,01; LW addr 0x31 -> 0x01020304, resp_valid 5 cycles after accept.
REQ-023 Without MISALIGNED_SPLIT_EN: LH addr 0x41 -> resp_valid=1, misalign_err=1 one cycle after accept, zero strobes.
REQ-024 rst pulsed during second byte of a split SW at 0x51 -> no strobe while rst high, no resp_valid, req_ready=1 the cycle after rst falls; only byte 0x51 modified.
